// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked by the
// device, ACK check. Shares the open-collector lines with the PS/2 receiver.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_NACK, S_WAITIDLE
  } state_t;

  logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic             r_clk_filt, r_fall;
  logic [FLT_W-1:0] r_flt_cnt;

  state_t           r_state;
  logic [9:0]       r_shift;
  logic [3:0]       r_bits;
  logic [INH_W-1:0] r_inh;
  logic [TMO_W-1:0] r_tmo;
  logic             w_tmo_hit;

  assign w_tmo_hit = (r_tmo == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1   <= '0;
      r_clk_s2   <= '0;
      r_dat_s1   <= '0;
      r_dat_s2   <= '0;
      r_clk_filt <= 1'b1;
      r_fall     <= 1'b0;
      r_flt_cnt  <= '0;
    end else begin
      r_clk_s1 <= ps2_clk_i;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_i;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      if (r_clk_s2 == r_clk_filt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FLT_LAST) begin
        r_flt_cnt  <= '0;
        r_clk_filt <= r_clk_s2;
        r_fall     <= r_clk_filt;
      end else begin
        r_flt_cnt <= r_flt_cnt + FLT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bits      <= '0;
      r_inh       <= '0;
      r_tmo       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          busy        <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          // busy is still high in the done/error cycle, so a request there is dropped
          if (tx_start && !busy) begin
            r_shift    <= {1'b1, ~^tx_data, tx_data};
            r_inh      <= '0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            r_state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          r_inh <= r_inh + INH_W'(1);
          if (r_inh == INH_DATA) ps2_data_oe <= 1'b1;
          if (r_inh == INH_LAST) begin
            ps2_clk_oe <= 1'b0;
            r_tmo      <= '0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          r_bits  <= '0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (r_fall) begin
            ps2_data_oe <= ~r_shift[0];
            r_shift     <= {1'b0, r_shift[9:1]};
            r_bits      <= r_bits + 4'd1;
            if (r_bits == 4'd9) r_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (r_fall) r_state <= r_dat_s2 ? S_NACK : S_WAITIDLE;
        end
        S_NACK: begin
          error   <= 1'b1;
          r_state <= S_IDLE;
        end
        S_WAITIDLE: begin
          if (r_clk_filt && r_dat_s2) begin
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Timeout overrides whatever the state logic above scheduled this cycle.
      if (r_state inside {S_REQ, S_SEND, S_ACK}) begin
        r_tmo <= r_tmo + TMO_W'(1);
        if (w_tmo_hit) begin
          error       <= 1'b1;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          r_state     <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on open-collector lines,
// frame contents compared with a parity/framing reference model.
module tb_ps2_host_tx;

  localparam int unsigned INH = 40;
  localparam int unsigned TMO = 3000;
  localparam int unsigned FLT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy, done, error, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .ps2_clk_i  (ps2_clk_line),
    .ps2_data_i (ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_done = 0, n_err = 0, n_both = 0, oe_run = 0, oe_last = 0;

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (error === 1'b1) n_err++;
    if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) n_both++;
    if (ps2_clk_oe === 1'b1) oe_run++;
    else if (oe_run != 0) begin
      oe_last = oe_run;
      oe_run  = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Bits as the device sees them, in line order: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int unsigned ones = 0;
    for (int unsigned i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  // mode 0: device ACKs, 1: device NACKs, 2: device never clocks
  task automatic run_frame(input logic [7:0] b, input int unsigned mode, input bit inject);
    logic [10:0] got;
    int unsigned d0, e0, b0, half, t;
    bit          seen;
    got  = '0;
    half = $urandom_range(24, FLT + 8);
    d0 = n_done; e0 = n_err; b0 = n_both;
    tx_data  = b;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_rise", busy, 1);
    seen = 0; t = 0;
    while (t < INH + 4 && !seen) begin
      tick(); t++;
      seen = (ps2_clk_oe === 1'b0);
    end
    check("inhibit_seen", seen, 1);
    check("inhibit_len", oe_last, INH);
    check("start_lead", n_both - b0, 1);
    check("req_data_low", ps2_data_line, 0);

    if (mode == 2) begin
      seen = 0; t = 0;
      while (t < TMO + 10 && !seen) begin
        tick(); t++;
        seen = (error === 1'b1);
      end
      check("tmo_seen", seen, 1);
      check("tmo_cycles", t, TMO);
      check("tmo_lines", {ps2_clk_oe, ps2_data_oe}, 0);
      check("tmo_busy", busy, 1);
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      check("tmo_busy_drop", busy, 0);
      check("tmo_no_accept", ps2_clk_oe, 0);
    end else begin
      repeat ($urandom_range(30, FLT + 8)) tick();
      for (int k = 0; k < 11; k++) begin
        got[k] = ps2_data_line;
        if (k == 10 && mode == 0) dev_data_low = 1'b1;
        dev_clk_low = 1'b1;
        repeat (half) tick();
        if (inject && k == 4) begin
          tx_data  = 8'h55;
          tx_start = 1'b1;
          tick();
          tx_start = 1'b0;
        end
        dev_clk_low = 1'b0;
        repeat (half) tick();
      end
      dev_data_low = 1'b0;
      check("frame", got, ref_frame(b));
      if (mode == 0) begin
        seen = 0; t = 0;
        while (t < 200 && !seen) begin
          tick(); t++;
          seen = (done === 1'b1);
        end
        check("done_seen", seen, 1);
        check("done_busy", busy, 1);
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("done_busy_drop", busy, 0);
        check("done_no_accept", ps2_clk_oe, 0);
      end else begin
        repeat (20) tick();
      end
    end
    repeat (10) tick();
    check("n_done", n_done - d0, (mode == 0) ? 1 : 0);
    check("n_err", n_err - e0, (mode == 0) ? 0 : 1);
  endtask

  initial begin
    int unsigned d0, e0;
    rst = 1'b1; tx_start = 1'b0; tx_data = '0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) tick();
    check("rst_outs", {busy, done, error, ps2_clk_oe, ps2_data_oe}, 0);
    rst = 1'b0;
    repeat (5) tick();

    d0 = n_done; e0 = n_err;
    tx_data  = 8'hED;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (10) tick();
    check("mid_inhibit", ps2_clk_oe, 1);
    rst = 1'b1;
    #1;
    check("rst_mid", {busy, ps2_clk_oe, ps2_data_oe}, 0);
    tick();
    rst = 1'b0;
    repeat (INH + 50) tick();
    check("rst_no_done", n_done - d0, 0);
    check("rst_no_err", n_err - e0, 0);
    check("rst_idle", {busy, ps2_clk_oe, ps2_data_oe}, 0);

    run_frame(8'hED, 0, 0);
    run_frame(8'h00, 0, 0);
    run_frame(8'h01, 0, 0);
    run_frame(8'hFF, 0, 0);
    run_frame(8'($urandom), 2, 0);
    run_frame(8'hA5, 1, 0);
    run_frame(8'hF4, 0, 0);
    run_frame(8'hED, 0, 1);
    for (int i = 0; i < 16; i++)
      run_frame(8'($urandom), ($urandom_range(0, 4) == 0) ? 1 : 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
